// File: rtl/ldpc_codeword_collector.sv
// ldpc_codeword_collector
// Detects the end of an LDPC decode, collects the MAX_COLS-word result burst,
// packs the left-aligned block bits of the first C words LSB-first into one
// codeword, and offers it downstream over a valid/ready handshake.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   block_size_in   bits per block (0 means MAX_BLOCK_SIZE)
//   cols_in         meaningful words per burst (clamped to MAX_COLS)
//   dec_done        decoder done level; a 0->1 edge starts a collection
//   dec_valid       decoder parity-check verdict, latched at start
//   dec_data        decoder output word, block bits on the MSB side
//   cw_out, cw_len  packed codeword and its meaningful bit count
//   cw_ok           latched decoder verdict
//   out_valid       result valid; out_ready accepts it
//   busy            collecting or holding a result
//   overrun         sticky: a done edge arrived while busy
module ldpc_codeword_collector #(
  parameter int unsigned MAX_BLOCK_SIZE = 64,
  parameter int unsigned MAX_COLS       = 32,
  localparam int unsigned MAX_CODE_LEN  = MAX_COLS * MAX_BLOCK_SIZE,
  localparam int unsigned WIDTH_BLOCK   = $clog2(MAX_BLOCK_SIZE),
  localparam int unsigned WIDTH_COLS    = $clog2(MAX_COLS + 1),
  localparam int unsigned WIDTH_LEN     = WIDTH_COLS + WIDTH_BLOCK + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH_BLOCK-1:0]    block_size_in,
  input  logic [WIDTH_COLS-1:0]     cols_in,
  input  logic                      dec_done,
  input  logic                      dec_valid,
  input  logic [MAX_BLOCK_SIZE-1:0] dec_data,
  output logic [MAX_CODE_LEN-1:0]   cw_out,
  output logic [WIDTH_LEN-1:0]      cw_len,
  output logic                      cw_ok,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      overrun
);

  // Block size needs one extra bit to represent MAX_BLOCK_SIZE itself.
  localparam int unsigned WIDTH_B   = WIDTH_BLOCK + 1;
  localparam int unsigned WIDTH_OFS = $clog2(MAX_CODE_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_HOLD
  } state_t;

  state_t                    state_q;
  state_t                    state_d;

  logic                      done_q;
  logic [WIDTH_B-1:0]        blk_q;
  logic [WIDTH_COLS-1:0]     cols_q;
  logic [WIDTH_COLS-1:0]     k_q;
  logic [MAX_CODE_LEN-1:0]   acc_q;

  logic                      start_c;
  logic [WIDTH_B-1:0]        blk_in_c;
  logic [WIDTH_COLS-1:0]     cols_in_c;
  logic [MAX_BLOCK_SIZE-1:0] word_c;
  logic [WIDTH_OFS-1:0]      offset_c;
  logic [MAX_CODE_LEN-1:0]   acc_next_c;
  logic                      last_c;
  logic [WIDTH_LEN-1:0]      len_c;

  // Start on the rising edge of the done level only.
  assign start_c = dec_done & ~done_q;

  // Normalised burst parameters captured at start.
  assign blk_in_c  = (block_size_in == '0) ? WIDTH_B'(MAX_BLOCK_SIZE)
                                           : WIDTH_B'(block_size_in);
  assign cols_in_c = (cols_in > WIDTH_COLS'(MAX_COLS)) ? WIDTH_COLS'(MAX_COLS)
                                                       : cols_in;

  // Right-align the B block bits; the shift also zeroes everything above them,
  // so the OR into the cleared accumulator needs no mask.
  assign word_c     = dec_data >> (WIDTH_B'(MAX_BLOCK_SIZE) - blk_q);
  assign offset_c   = WIDTH_OFS'(k_q) * WIDTH_OFS'(blk_q);
  assign acc_next_c = (k_q < cols_q) ? (acc_q | (MAX_CODE_LEN'(word_c) << offset_c))
                                     : acc_q;
  assign last_c     = (k_q == WIDTH_COLS'(MAX_COLS - 1));
  assign len_c      = WIDTH_LEN'(cols_q) * WIDTH_LEN'(blk_q);

  assign busy = (state_q != S_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; HOLD always has out_valid set, so out_ready alone
  // completes the handshake there.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_c)   state_d = S_COLLECT;
      S_COLLECT: if (last_c)    state_d = S_HOLD;
      S_HOLD:    if (out_ready) state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q    <= 1'b0;
      blk_q     <= '0;
      cols_q    <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      cw_out    <= '0;
      cw_len    <= '0;
      cw_ok     <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done_q <= dec_done;

      // Any edge outside IDLE (including the handshake cycle) is dropped.
      if (start_c && (state_q != S_IDLE)) begin
        overrun <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (start_c) begin
            blk_q  <= blk_in_c;
            cols_q <= cols_in_c;
            cw_ok  <= dec_valid;
            acc_q  <= '0;
            k_q    <= '0;
          end
        end
        S_COLLECT: begin
          acc_q <= acc_next_c;
          k_q   <= k_q + WIDTH_COLS'(1);
          if (last_c) begin
            cw_out    <= acc_next_c;
            cw_len    <= len_c;
            out_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
